// File: rtl/npu_seq_pkg.sv
// Shared limits, widths, state encoding and beat layout for the NPU tile loop sequencer.
// calc_meta derives addresses and accumulator flags for one loop position.
package npu_seq_pkg;

    localparam int K         = 5;
    localparam int KK        = K * K;
    localparam int W         = 16;
    localparam int MAX_TILE  = 4;
    localparam int MAX_TILEB = 16;
    localparam int MAX_TILEC = 16;

    localparam int TW  = $clog2(MAX_TILE + 1);
    localparam int BW  = $clog2(MAX_TILEB + 1);
    localparam int CW  = $clog2(MAX_TILEC + 1);
    localparam int KLW = $clog2(KK + 1);
    localparam int TIW = $clog2(MAX_TILE);
    localparam int BIW = $clog2(MAX_TILEB);
    localparam int CIW = $clog2(MAX_TILEC);
    localparam int KIW = $clog2(KK);
    localparam int WAW = $clog2(MAX_TILEC * MAX_TILEB * KK);
    localparam int AAW = $clog2(MAX_TILE * MAX_TILE * MAX_TILEB);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic [WAW-1:0] w_addr;
        logic [AAW-1:0] a_addr;
        logic           acc_clr;
        logic           acc_wb;
        logic           last;
    } meta_t;

    typedef struct packed {
        logic [CIW-1:0] c_idx;
        logic [TIW-1:0] tr_idx;
        logic [TIW-1:0] tc_idx;
        logic [BIW-1:0] b_idx;
        logic [KIW-1:0] k_idx;
        logic [WAW-1:0] w_addr;
        logic [AAW-1:0] a_addr;
        logic           acc_clr;
        logic           acc_wb;
        logic           last;
    } beat_t;

    function automatic logic cfg_legal(input logic [TW-1:0] nbt,
                                       input logic [BW-1:0] nbb,
                                       input logic [CW-1:0] nbc);
        return (nbt != '0) && (int'(nbt) <= MAX_TILE) &&
               (nbb != '0) && (int'(nbb) <= MAX_TILEB) &&
               (nbc != '0) && (int'(nbc) <= MAX_TILEC);
    endfunction

    function automatic meta_t calc_meta(input logic [CIW-1:0] c,
                                        input logic [TIW-1:0] tr,
                                        input logic [TIW-1:0] tc,
                                        input logic [BIW-1:0] b,
                                        input logic [KIW-1:0] k,
                                        input logic [TW-1:0]  nbt,
                                        input logic [BW-1:0]  nbb,
                                        input logic [CW-1:0]  nbc);
        meta_t          m;
        logic [WAW-1:0] cb;
        logic [AAW-1:0] rc;
        cb        = WAW'(c) * WAW'(nbb) + WAW'(b);
        m.w_addr  = cb * WAW'(KK) + WAW'(k);
        rc        = AAW'(tr) * AAW'(nbt) + AAW'(tc);
        m.a_addr  = rc * AAW'(nbb) + AAW'(b);
        m.acc_clr = (b == '0) && (k == '0);
        m.acc_wb  = (BW'(b) == nbb - BW'(1)) && (k == KIW'(KK - 1));
        m.last    = m.acc_wb && (CW'(c) == nbc - CW'(1)) &&
                    (TW'(tr) == nbt - TW'(1)) && (TW'(tc) == nbt - TW'(1));
        return m;
    endfunction

endpackage

// File: rtl/tile_loop_sequencer_wrap_counter.sv
// Up-counter with a runtime limit: wraps to 0 after limit-1; wrap flags the terminal count.
// nxt_o exposes the value the counter takes at the next edge so callers can register derived data.
module wrap_counter #(
    parameter int CNT_W = 4,
    parameter int LIM_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [LIM_W-1:0] limit_i,
    output logic [CNT_W-1:0] count_o,
    output logic [CNT_W-1:0] nxt_o,
    output logic             wrap_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign wrap_o = (LIM_W'(count_q) == limit_i - LIM_W'(1));

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = wrap_o ? '0 : count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign nxt_o   = count_d;

endmodule

// File: rtl/tile_loop_sequencer.sv
// Runtime-configured loop nest (c, tr, tc, b, k) emitting one beat per handshake; first beat 1 cycle after start.
// Beat outputs are registered and hold while out_valid && !out_ready; abort wins over a same-cycle handshake.
module tile_loop_sequencer
    import npu_seq_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           abort,
    input  logic [TW-1:0]  cfg_nb_tile,
    input  logic [BW-1:0]  cfg_nb_tileb,
    input  logic [CW-1:0]  cfg_nb_tilec,
    output logic           busy,
    output logic           done,
    output logic           cfg_err,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [CIW-1:0] c_idx,
    output logic [TIW-1:0] tr_idx,
    output logic [TIW-1:0] tc_idx,
    output logic [BIW-1:0] b_idx,
    output logic [KIW-1:0] k_idx,
    output logic [WAW-1:0] w_addr,
    output logic [AAW-1:0] a_addr,
    output logic           acc_clr,
    output logic           acc_wb,
    output logic           last
);

    localparam logic [KLW-1:0] KK_LIM = KLW'(KK);

    state_e        state_q, state_d;
    logic          valid_q, valid_d;
    logic          err_q, err_d;
    logic [TW-1:0] nbt_q, nbt_d;
    logic [BW-1:0] nbb_q, nbb_d;
    logic [CW-1:0] nbc_q, nbc_d;
    meta_t         meta_q, meta_d;
    beat_t         beat;

    logic [CIW-1:0] cnt_c, nxt_c;
    logic [TIW-1:0] cnt_tr, nxt_tr, cnt_tc, nxt_tc;
    logic [BIW-1:0] cnt_b, nxt_b;
    logic [KIW-1:0] cnt_k, nxt_k;
    logic           wrap_c, wrap_tr, wrap_tc, wrap_b, wrap_k;
    logic           hs, final_hs, adv, clr;
    logic           en_b, en_tc, en_tr, en_c;

    assign hs       = (state_q == ST_RUN) && valid_q && out_ready && !abort;
    assign final_hs = hs && wrap_c && wrap_tr && wrap_tc && wrap_b && wrap_k;
    assign adv      = hs && !final_hs;
    assign clr      = ((state_q == ST_IDLE) && start) || ((state_q != ST_IDLE) && abort);

    // Carry ripples outward only when every inner index sits at its terminal count.
    assign en_b  = adv  && wrap_k;
    assign en_tc = en_b && wrap_b;
    assign en_tr = en_tc && wrap_tc;
    assign en_c  = en_tr && wrap_tr;

    wrap_counter #(.CNT_W(KIW), .LIM_W(KLW)) u_cnt_k (
        .clk(clk), .rst(rst), .clr_i(clr), .en_i(adv), .limit_i(KK_LIM),
        .count_o(cnt_k), .nxt_o(nxt_k), .wrap_o(wrap_k)
    );

    wrap_counter #(.CNT_W(BIW), .LIM_W(BW)) u_cnt_b (
        .clk(clk), .rst(rst), .clr_i(clr), .en_i(en_b), .limit_i(nbb_q),
        .count_o(cnt_b), .nxt_o(nxt_b), .wrap_o(wrap_b)
    );

    wrap_counter #(.CNT_W(TIW), .LIM_W(TW)) u_cnt_tc (
        .clk(clk), .rst(rst), .clr_i(clr), .en_i(en_tc), .limit_i(nbt_q),
        .count_o(cnt_tc), .nxt_o(nxt_tc), .wrap_o(wrap_tc)
    );

    wrap_counter #(.CNT_W(TIW), .LIM_W(TW)) u_cnt_tr (
        .clk(clk), .rst(rst), .clr_i(clr), .en_i(en_tr), .limit_i(nbt_q),
        .count_o(cnt_tr), .nxt_o(nxt_tr), .wrap_o(wrap_tr)
    );

    wrap_counter #(.CNT_W(CIW), .LIM_W(CW)) u_cnt_c (
        .clk(clk), .rst(rst), .clr_i(clr), .en_i(en_c), .limit_i(nbc_q),
        .count_o(cnt_c), .nxt_o(nxt_c), .wrap_o(wrap_c)
    );

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        err_d   = err_q;
        nbt_d   = nbt_q;
        nbb_d   = nbb_q;
        nbc_d   = nbc_q;
        meta_d  = meta_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (cfg_legal(cfg_nb_tile, cfg_nb_tileb, cfg_nb_tilec)) begin
                        state_d = ST_RUN;
                        valid_d = 1'b1;
                        err_d   = 1'b0;
                        nbt_d   = cfg_nb_tile;
                        nbb_d   = cfg_nb_tileb;
                        nbc_d   = cfg_nb_tilec;
                        meta_d  = calc_meta('0, '0, '0, '0, '0,
                                            cfg_nb_tile, cfg_nb_tileb, cfg_nb_tilec);
                    end else begin
                        state_d = ST_DONE;
                        err_d   = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                    meta_d  = '0;
                end else if (final_hs) begin
                    state_d = ST_DONE;
                    valid_d = 1'b0;
                end else if (adv) begin
                    meta_d = calc_meta(nxt_c, nxt_tr, nxt_tc, nxt_b, nxt_k,
                                       nbt_q, nbb_q, nbc_q);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                if (abort) begin
                    meta_d = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            nbt_q   <= '0;
            nbb_q   <= '0;
            nbc_q   <= '0;
            meta_q  <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            nbt_q   <= nbt_d;
            nbb_q   <= nbb_d;
            nbc_q   <= nbc_d;
            meta_q  <= meta_d;
        end
    end

    always_comb begin
        beat         = '0;
        beat.c_idx   = cnt_c;
        beat.tr_idx  = cnt_tr;
        beat.tc_idx  = cnt_tc;
        beat.b_idx   = cnt_b;
        beat.k_idx   = cnt_k;
        beat.w_addr  = meta_q.w_addr;
        beat.a_addr  = meta_q.a_addr;
        beat.acc_clr = meta_q.acc_clr;
        beat.acc_wb  = meta_q.acc_wb;
        beat.last    = meta_q.last;
    end

    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign cfg_err   = err_q;
    assign out_valid = valid_q;
    assign c_idx     = beat.c_idx;
    assign tr_idx    = beat.tr_idx;
    assign tc_idx    = beat.tc_idx;
    assign b_idx     = beat.b_idx;
    assign k_idx     = beat.k_idx;
    assign w_addr    = beat.w_addr;
    assign a_addr    = beat.a_addr;
    assign acc_clr   = beat.acc_clr;
    assign acc_wb    = beat.acc_wb;
    assign last      = beat.last;

endmodule

// File: tb/tb_tile_loop_sequencer.sv
// Scoreboard bench for tile_loop_sequencer: expected beats queued at launch, popped on each handshake.
module tb_tile_loop_sequencer;
    import npu_seq_pkg::*;

    logic           clk = 1'b0;
    logic           rst, start, abort, out_ready;
    logic [TW-1:0]  cfg_nb_tile;
    logic [BW-1:0]  cfg_nb_tileb;
    logic [CW-1:0]  cfg_nb_tilec;
    logic           busy, done, cfg_err, out_valid, acc_clr, acc_wb, last;
    logic [CIW-1:0] c_idx;
    logic [TIW-1:0] tr_idx, tc_idx;
    logic [BIW-1:0] b_idx;
    logic [KIW-1:0] k_idx;
    logic [WAW-1:0] w_addr;
    logic [AAW-1:0] a_addr;

    int    n_tests = 0;
    int    n_fail  = 0;
    beat_t exp_q[$];
    int    got_beats, got_clr, got_wb, got_done, hs_last_cyc, done_cyc;
    beat_t first_obs, obs150, last_obs;

    always #5 clk = ~clk;

    tile_loop_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .cfg_nb_tile(cfg_nb_tile), .cfg_nb_tileb(cfg_nb_tileb), .cfg_nb_tilec(cfg_nb_tilec),
        .busy(busy), .done(done), .cfg_err(cfg_err), .out_valid(out_valid), .out_ready(out_ready),
        .c_idx(c_idx), .tr_idx(tr_idx), .tc_idx(tc_idx), .b_idx(b_idx), .k_idx(k_idx),
        .w_addr(w_addr), .a_addr(a_addr), .acc_clr(acc_clr), .acc_wb(acc_wb), .last(last)
    );

    function automatic beat_t cur_beat();
        beat_t o;
        o.c_idx = c_idx;   o.tr_idx = tr_idx; o.tc_idx = tc_idx;
        o.b_idx = b_idx;   o.k_idx = k_idx;
        o.w_addr = w_addr; o.a_addr = a_addr;
        o.acc_clr = acc_clr; o.acc_wb = acc_wb; o.last = last;
        return o;
    endfunction

    task automatic push_layer(input int nt, input int nb, input int nc);
        beat_t e;
        for (int c = 0; c < nc; c++)
            for (int tr = 0; tr < nt; tr++)
                for (int tc = 0; tc < nt; tc++)
                    for (int b = 0; b < nb; b++)
                        for (int k = 0; k < KK; k++) begin
                            e.c_idx   = CIW'(c);
                            e.tr_idx  = TIW'(tr);
                            e.tc_idx  = TIW'(tc);
                            e.b_idx   = BIW'(b);
                            e.k_idx   = KIW'(k);
                            e.w_addr  = WAW'((c * nb + b) * KK + k);
                            e.a_addr  = AAW'((tr * nt + tc) * nb + b);
                            e.acc_clr = (b == 0) && (k == 0);
                            e.acc_wb  = (b == nb - 1) && (k == KK - 1);
                            e.last    = 1'b0;
                            exp_q.push_back(e);
                        end
        exp_q[exp_q.size() - 1].last = 1'b1;
    endtask

    // Called at a negedge; returns at the negedge where the first beat is visible.
    task automatic launch(input int nt, input int nb, input int nc);
        cfg_nb_tile  = TW'(nt);
        cfg_nb_tileb = BW'(nb);
        cfg_nb_tilec = CW'(nc);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cfg_nb_tile  = '0;
        cfg_nb_tileb = '0;
        cfg_nb_tilec = '0;
    endtask

    task automatic run_stream(input int ready_pct, input int abort_at);
        beat_t obs, prev;
        bit    stalled = 1'b0;
        bit    fin = 1'b0;
        int    cyc = 0;
        got_beats = 0; got_clr = 0; got_wb = 0; got_done = 0;
        hs_last_cyc = -1; done_cyc = -1;
        prev = '0;
        while (!fin) begin
            obs = cur_beat();
            if (done === 1'b1) begin
                got_done++;
                done_cyc = cyc;
            end
            if (out_valid === 1'b1) begin
                if (stalled) begin
                    n_tests++;
                    if (obs !== prev) begin
                        n_fail++;
                        $display("FAIL stall_hold beat%0d got=%h need=%h", got_beats, obs, prev);
                    end
                end
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL extra_beat got=%h need=no beat", obs);
                    fin = 1'b1;
                end else if (obs !== exp_q[0]) begin
                    n_fail++;
                    $display("FAIL beat%0d got=%h need=%h", got_beats, obs, exp_q[0]);
                end
                if (!fin && abort_at >= 0 && got_beats == abort_at) begin
                    abort = 1'b1;
                    out_ready = 1'b1;
                    @(negedge clk);
                    abort = 1'b0;
                    cyc++;
                    n_tests++;
                    if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
                        n_fail++;
                        $display("FAIL abort_stop got valid=%b busy=%b done=%b need 0 0 0",
                                 out_valid, busy, done);
                    end
                    exp_q.delete();
                    fin = 1'b1;
                end else if (!fin) begin
                    out_ready = ($urandom_range(99) < ready_pct);
                    if (out_ready) begin
                        if (got_beats == 0)   first_obs = obs;
                        if (got_beats == 149) obs150 = obs;
                        if (obs.acc_clr) got_clr++;
                        if (obs.acc_wb)  got_wb++;
                        if (obs.last)    hs_last_cyc = cyc;
                        last_obs = obs;
                        got_beats++;
                        if (exp_q.size() > 0) void'(exp_q.pop_front());
                        stalled = 1'b0;
                    end else begin
                        stalled = 1'b1;
                        prev = obs;
                    end
                end
            end else begin
                stalled = 1'b0;
                if (done_cyc >= 0 && cyc > done_cyc) fin = 1'b1;
            end
            if (!fin && cyc > 30000) begin
                n_tests++;
                n_fail++;
                $display("FAIL stream_timeout got beats=%0d need done within 30000 cycles", got_beats);
                fin = 1'b1;
            end
            if (!fin) begin
                @(negedge clk);
                cyc++;
            end
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
        cfg_nb_tile = '0; cfg_nb_tileb = '0; cfg_nb_tilec = '0;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({busy, done, cfg_err, out_valid} !== 4'b0 || cur_beat() !== '0) begin
            n_fail++;
            $display("FAIL reset_state got flags=%b beat=%h need 0", {busy, done, cfg_err, out_valid}, cur_beat());
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++;
        if ({busy, done, cfg_err, out_valid} !== 4'b0 || cur_beat() !== '0) begin
            n_fail++;
            $display("FAIL post_reset_idle got flags=%b beat=%h need 0", {busy, done, cfg_err, out_valid}, cur_beat());
        end
    endtask

    task automatic test_layer1();
        push_layer(4, 1, 6);
        launch(4, 1, 6);
        run_stream(100, -1);
        n_tests++;
        if (got_beats != 2400 || got_clr != 96 || got_wb != 96) begin
            n_fail++;
            $display("FAIL l1_counts got beats=%0d clr=%0d wb=%0d need 2400 96 96", got_beats, got_clr, got_wb);
        end
        n_tests++;
        if (last_obs.w_addr !== 13'd149 || last_obs.a_addr !== 8'd15 || last_obs.last !== 1'b1) begin
            n_fail++;
            $display("FAIL l1_last_beat got w=%0d a=%0d last=%b need 149 15 1",
                     last_obs.w_addr, last_obs.a_addr, last_obs.last);
        end
        n_tests++;
        if (got_done != 1 || done_cyc - hs_last_cyc != 1) begin
            n_fail++;
            $display("FAIL l1_done got pulses=%0d delay=%0d need 1 1", got_done, done_cyc - hs_last_cyc);
        end
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL l1_idle got busy=%b done=%b left=%0d need 0 0 0", busy, done, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_layer2();
        push_layer(2, 6, 16);
        launch(2, 6, 16);
        run_stream(100, -1);
        n_tests++;
        if (got_beats != 9600 || got_done != 1) begin
            n_fail++;
            $display("FAIL l2_count got beats=%0d done=%0d need 9600 1", got_beats, got_done);
        end
        n_tests++;
        if (first_obs.acc_clr !== 1'b1 || first_obs.w_addr !== 13'd0) begin
            n_fail++;
            $display("FAIL l2_first got clr=%b w=%0d need 1 0", first_obs.acc_clr, first_obs.w_addr);
        end
        n_tests++;
        if (obs150.acc_wb !== 1'b1 || obs150.w_addr !== 13'd149 || obs150.a_addr !== 8'd5) begin
            n_fail++;
            $display("FAIL l2_beat150 got wb=%b w=%0d a=%0d need 1 149 5", obs150.acc_wb, obs150.w_addr, obs150.a_addr);
        end
        n_tests++;
        if (last_obs.w_addr !== 13'd2399 || last_obs.a_addr !== 8'd23) begin
            n_fail++;
            $display("FAIL l2_last got w=%0d a=%0d need 2399 23", last_obs.w_addr, last_obs.a_addr);
        end
        exp_q.delete();
    endtask

    task automatic test_backpressure();
        push_layer(1, 1, 1);
        launch(1, 1, 1);
        run_stream(30, -1);
        n_tests++;
        if (got_beats != 25 || got_done != 1 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL bp_counts got beats=%0d done=%0d left=%0d need 25 1 0", got_beats, got_done, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic cfg_err_case(input int nt, input int nb, input int nc, input string name);
        cfg_nb_tile = TW'(nt); cfg_nb_tileb = BW'(nb); cfg_nb_tilec = CW'(nc);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_tests++;
        if (cfg_err !== 1'b1 || busy !== 1'b1 || done !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_pulse got err=%b busy=%b done=%b valid=%b need 1 1 1 0",
                     name, cfg_err, busy, done, out_valid);
        end
        @(negedge clk);
        n_tests++;
        if (cfg_err !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_after got err=%b busy=%b done=%b valid=%b need 1 0 0 0",
                     name, cfg_err, busy, done, out_valid);
        end
    endtask

    task automatic test_cfg_err();
        cfg_err_case(4, 0, 6, "tileb_zero");
        cfg_err_case(5, 1, 6, "tile_over");
        cfg_err_case(1, 17, 1, "tileb_over");
    endtask

    task automatic test_abort();
        push_layer(4, 1, 6);
        launch(4, 1, 6);
        n_tests++;
        if (cfg_err !== 1'b0) begin
            n_fail++;
            $display("FAIL start_clears_err got %b need 0", cfg_err);
        end
        run_stream(100, 100);
        repeat (3) @(negedge clk);
        n_tests++;
        if (got_done != 0 || done !== 1'b0 || busy !== 1'b0 || got_beats != 100) begin
            n_fail++;
            $display("FAIL abort_idle got done=%0d busy=%b beats=%0d need 0 0 100", got_done, busy, got_beats);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_tests++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_in_idle got busy=%b valid=%b done=%b need 0 0 0", busy, out_valid, done);
        end
        push_layer(4, 1, 6);
        launch(4, 1, 6);
        run_stream(100, 0);
        exp_q.delete();
    endtask

    task automatic test_async_reset();
        push_layer(4, 1, 6);
        launch(4, 1, 6);
        out_ready = 1'b1;
        repeat (40) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if ({busy, done, cfg_err, out_valid} !== 4'b0 || cur_beat() !== '0) begin
            n_fail++;
            $display("FAIL async_reset got flags=%b beat=%h need 0", {busy, done, cfg_err, out_valid}, cur_beat());
        end
        out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({busy, done, cfg_err, out_valid} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_release got flags=%b need 0", {busy, done, cfg_err, out_valid});
        end
        exp_q.delete();
        cfg_err_case(0, 1, 1, "tile_zero");
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if (cfg_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_clears_err got %b need 0", cfg_err);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_layer1();
        test_layer2();
        test_backpressure();
        test_cfg_err();
        test_abort();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
